// File: rtl/reg_write_arbiter.sv
// Register-file write-port owner: boot-value init pass, then
// round-robin sharing between ALU and load writeback.
module reg_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              init_done,
  output logic              Load,
  output logic [ADDR_W-1:0] Caddr,
  output logic [DATA_W-1:0] C
);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              last;

  logic              run_ok;
  logic              gnt0;
  logic              gnt1;
  logic [ADDR_W-1:0] gaddr;
  logic [DATA_W-1:0] gdata;

  function automatic logic [DATA_W-1:0] boot(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] v;
    v = '0;
    if (a == ADDR_W'(1)) v = DATA_W'(1);
    if (a == ADDR_W'(2)) v = DATA_W'(2);
    if (a == ADDR_W'(5)) v = DATA_W'(1);
    return v;
  endfunction

  // last==1 means req1 won most recently, so req0 has priority
  always_comb begin
    run_ok = !rst && (state == RUN);
    gnt0   = run_ok && req0_valid &&
             (!req1_valid || last);
    gnt1   = run_ok && req1_valid &&
             (!req0_valid || !last);
    gaddr  = gnt1 ? req1_addr : req0_addr;
    gdata  = gnt1 ? req1_data : req0_data;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      last      <= 1'b1;
      Load      <= 1'b0;
      Caddr     <= '0;
      C         <= '0;
      init_done <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          Load  <= 1'b1;
          Caddr <= cnt;
          C     <= boot(cnt);
          cnt   <= cnt + ADDR_W'(1);
          if (cnt == ADDR_W'(NREGS - 1))
            state <= RUN;
        end
        RUN: begin
          init_done <= 1'b1;
          Load      <= 1'b0;
          if (gnt0 || gnt1) begin
            last <= gnt1;
            // $zero: retire the request, suppress the write
            if (gaddr != '0) begin
              Load  <= 1'b1;
              Caddr <= gaddr;
              C     <= gdata;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboarded random/directed bench for reg_write_arbiter.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [3:0]  req0_addr = '0;
  logic [15:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [3:0]  req1_addr = '0;
  logic [15:0] req1_data = '0;
  logic        req1_ready;
  logic        init_done;
  logic        Load;
  logic [3:0]  Caddr;
  logic [15:0] C;

  reg_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .init_done(init_done), .Load(Load),
    .Caddr(Caddr), .C(C)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [19:0] expq[$];
  logic        rst_q = 1'b1;
  always @(posedge clk) rst_q <= rst;

  logic        rst_cmd = 1'b1;
  logic        p0 = 0, p1 = 0;
  logic [3:0]  a0 = 0, a1 = 0;
  logic [15:0] d0 = 0, d1 = 0;
  int          edges = 0;
  int          prio = 0;

  function automatic logic [15:0] bootv(input int r);
    if (r == 1 || r == 5) return 16'h0001;
    if (r == 2) return 16'h0002;
    return 16'h0000;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, req, $time);
    end
  endtask

  task automatic step();
    logic ok, g0, g1;
    @(posedge clk);
    #1;
    rst = rst_cmd;
    req0_valid = p0; req0_addr = a0; req0_data = d0;
    req1_valid = p1; req1_addr = a1; req1_data = d1;
    #2;
    ok = !rst_cmd && edges >= 16;
    g0 = ok && p0 && (!p1 || prio == 0);
    g1 = ok && p1 && (!p0 || prio == 1);
    chk("req0_ready", 32'(req0_ready), 32'(g0));
    chk("req1_ready", 32'(req1_ready), 32'(g1));
    chk("init_done", 32'(init_done), 32'(edges >= 17));
    if (!rst_cmd && edges < 16)
      expq.push_back({4'(edges), bootv(edges)});
    if (g0) begin
      prio = 1; p0 = 0;
      if (a0 != 0) expq.push_back({a0, d0});
    end else if (g1) begin
      prio = 0; p1 = 0;
      if (a1 != 0) expq.push_back({a1, d1});
    end
    if (rst_cmd) begin
      edges = 0; prio = 0;
    end else begin
      edges++;
    end
  endtask

  task automatic offer0(input logic [3:0] a,
                        input logic [15:0] d);
    if (!p0) begin p0 = 1; a0 = a; d0 = d; end
  endtask

  task automatic offer1(input logic [3:0] a,
                        input logic [15:0] d);
    if (!p1) begin p1 = 1; a1 = a; d1 = d; end
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && (p0 || p1); i++) step();
    step(); step();
  endtask

  // monitor: pop expected write on every Load, else expect hold
  logic [3:0]  ea = 0;
  logic [15:0] ec = 0;
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        ea = 0; ec = 0;
        chk("reset_load", 32'(Load), 32'd0);
        chk("reset_caddr", 32'(Caddr), 32'd0);
        chk("reset_c", 32'(C), 32'd0);
      end else if (Load) begin
        if (expq.size() == 0) begin
          chk("unexpected_load", 32'(Load), 32'd0);
        end else begin
          e = expq.pop_front();
          ea = e[19:16]; ec = e[15:0];
          chk("write_caddr", 32'(Caddr), 32'(ea));
          chk("write_c", 32'(C), 32'(ec));
        end
      end else begin
        chk("hold_caddr", 32'(Caddr), 32'(ea));
        chk("hold_c", 32'(C), 32'(ec));
      end
    end
  end

  initial begin
    rst_cmd = 1;
    repeat (3) step();
    rst_cmd = 0;
    repeat (18) step();

    offer0(4'd3, 16'hBEEF);
    step(); step(); step();

    for (int i = 0; i < 8; i++) begin
      offer0(4'd4, 16'h1111);
      offer1(4'd6, 16'h2222);
      step();
    end
    drain();

    offer1(4'd0, 16'hFFFF);
    step(); step(); step();

    offer0(4'd8, 16'h0808);
    step();
    offer0(4'd7, 16'hAAAA);
    offer1(4'd7, 16'h5555);
    drain();

    rst_cmd = 1; step(); step();
    rst_cmd = 0;
    repeat (10) step();
    rst_cmd = 1; step();
    rst_cmd = 0;
    repeat (20) step();
    offer0(4'd9, 16'h9999);
    offer1(4'd10, 16'hA0A0);
    step();
    offer0(4'd11, 16'hB0B0);
    rst_cmd = 1; step(); step();
    rst_cmd = 0;
    repeat (20) step();
    drain();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 60)
        offer0(4'($urandom_range(15)), 16'($urandom));
      if ($urandom_range(99) < 60)
        offer1(4'($urandom_range(15)), 16'($urandom));
      rst_cmd = ($urandom_range(199) == 0);
      step();
    end
    rst_cmd = 0;
    repeat (18) step();
    drain();

    chk("queue_empty", 32'(expq.size()), 32'd0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
